// File: rtl/hazard_pkg.sv
// Shared types and constants for the RVX10 hazard/stall controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic {
    RUN    = 1'b0,
    EXWAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M result beats W result; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input reg_idx_t rs,
    input reg_idx_t rd_m,
    input logic     we_m,
    input reg_idx_t rd_w,
    input logic     we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the RVX10 5-stage pipeline: forwarding, load-use
// stall, branch flush, multi-cycle EX wait with watchdog, and perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  reg_idx_t         Rs1D,
  input  reg_idx_t         Rs2D,
  input  reg_idx_t         Rs1E,
  input  reg_idx_t         Rs2E,
  input  reg_idx_t         RdE,
  input  reg_idx_t         RdM,
  input  reg_idx_t         RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             ex_start,
  input  logic             ex_done,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             wd_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT);

  state_e            r_state;
  state_e            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_wd_err;
  logic              r_wd_flush;
  logic              w_lw;
  logic              w_timeout;
  logic              w_flush_any;

  assign w_lw = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // ex_done on the last allowed cycle still counts as a normal completion.
  assign w_timeout = (r_state == EXWAIT) && !ex_done &&
                     (r_wait == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (ex_start) w_next = EXWAIT;
      EXWAIT:  if (ex_done || w_timeout) w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      case (r_state)
        // A taken branch makes the D instruction wrong-path, so no load-use stall.
        RUN: begin
          StallF = w_lw && !PCSrcE;
          StallD = w_lw && !PCSrcE;
          FlushD = PCSrcE;
          FlushE = w_lw || PCSrcE || r_wd_flush;
        end
        EXWAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (r_state == RUN) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Timeout sets the sticky error and discards the hung op on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_err   <= 1'b0;
      r_wd_flush <= 1'b0;
    end else begin
      r_wd_err   <= r_wd_err | w_timeout;
      r_wd_flush <= w_timeout;
    end
  end

  assign wd_err      = r_wd_err;
  assign w_flush_any = FlushD || FlushE || FlushM;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_any),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int MAXW  = 8;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk;
  logic            reset;
  logic [4:0]      Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic            RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, ex_start, ex_done;
  logic            StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            wd_err;
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit m_wait, m_wd_err, m_pend;
  int m_waited, m_stall, m_flush;
  // model combinational expectations
  bit e_sf, e_sd, e_se, e_fd, e_fe, e_fm;
  logic [1:0] e_fa, e_fb;

  hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .ex_start(ex_start), .ex_done(ex_done),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .wd_err(wd_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    assert (!(ex_start && PCSrcE)) else $error("ex_start and PCSrcE high together");

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_wd_err = 0; m_pend = 0;
    m_waited = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_comb();
    bit lw;
    lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    {e_sf, e_sd, e_se, e_fd, e_fe, e_fm} = '0;
    e_fa = 2'b00;
    e_fb = 2'b00;
    if (!reset) begin
      e_fa = ref_fwd(Rs1E);
      e_fb = ref_fwd(Rs2E);
      if (m_wait) begin
        e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
      end else begin
        e_sf = lw && !PCSrcE;
        e_sd = e_sf;
        e_fd = PCSrcE;
        e_fe = lw || PCSrcE || m_pend;
      end
    end
  endtask

  task automatic model_edge();
    bit timeout;
    timeout = 0;
    if (e_sf && m_stall < CMAX) m_stall++;
    if ((e_fd || e_fe || e_fm) && m_flush < CMAX) m_flush++;
    if (m_wait) begin
      m_waited++;
      if (ex_done) m_wait = 0;
      else if (m_waited == MAXW) begin
        m_wait = 0;
        m_wd_err = 1;
        timeout = 1;
      end
    end else if (ex_start) begin
      m_wait = 1;
      m_waited = 0;
    end
    m_pend = timeout;
  endtask

  task automatic check_all();
    model_comb();
    check("StallF", 32'(StallF), 32'(e_sf));
    check("StallD", 32'(StallD), 32'(e_sd));
    check("StallE", 32'(StallE), 32'(e_se));
    check("FlushD", 32'(FlushD), 32'(e_fd));
    check("FlushE", 32'(FlushE), 32'(e_fe));
    check("FlushM", 32'(FlushM), 32'(e_fm));
    check("ForwardAE", 32'(ForwardAE), 32'(e_fa));
    check("ForwardBE", 32'(ForwardBE), 32'(e_fb));
    check("wd_err", 32'(wd_err), 32'(m_wd_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic cycle();
    #2 check_all();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, ex_start, ex_done} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    PCSrcE = 1'b1;
    ResultSrcE0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
    model_reset();
    #2 check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // forwarding priority and x0
    RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
    #1 check("fwdA_M", 32'(ForwardAE), 32'h2);
    cycle();
    RegWriteM = 0;
    #1 check("fwdA_W", 32'(ForwardAE), 32'h1);
    cycle();
    Rs1E = 0; RdM = 0; RegWriteM = 1;
    #1 check("fwdA_x0", 32'(ForwardAE), 32'h0);
    cycle();

    // load-use
    idle(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    cycle();
    idle();
    #1 check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    // branch overrides load-use
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
    #1 check("br_StallF", 32'(StallF), 32'd0);
    cycle();
    idle();
    #1 check("br_flush_cnt", 32'(flush_cnt), 32'd2);

    // multi-cycle op with ex_done after 4 wait cycles
    do_reset();
    idle(); ex_start = 1;
    cycle();
    ex_start = 0;
    repeat (3) cycle();
    ex_done = 1;
    cycle();
    ex_done = 0;
    cycle();
    #1 check("mc_stall_cnt", 32'(stall_cnt), 32'd4);
    check("mc_wd_err", 32'(wd_err), 32'd0);

    // watchdog
    ex_start = 1;
    cycle();
    ex_start = 0;
    repeat (MAXW) cycle();
    #1 check("wd_set", 32'(wd_err), 32'd1);
    check("wd_flushE", 32'(FlushE), 32'd1);
    cycle();
    ex_start = 1;
    cycle();
    ex_start = 0;
    cycle();
    ex_done = 1;
    cycle();
    ex_done = 0;
    cycle();
    #1 check("wd_sticky", 32'(wd_err), 32'd1);

    // async reset in the middle of EXWAIT
    ex_start = 1;
    cycle();
    ex_start = 0;
    repeat (2) cycle();
    #1 check("pre_rst_StallE", 32'(StallE), 32'd1);
    do_reset();

    // long load-use stall saturates stall_cnt
    idle(); ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
    repeat (CMAX + 5) cycle();
    idle();
    #1 check("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));
    cycle();

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      Rs1D = 5'($urandom_range(0, 3));
      Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3));
      Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3));
      RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM   = ($urandom_range(0, 1) == 1);
      RegWriteW   = ($urandom_range(0, 1) == 1);
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      PCSrcE      = ($urandom_range(0, 5) == 0);
      ex_start    = !PCSrcE && ($urandom_range(0, 9) == 0);
      ex_done     = ($urandom_range(0, 4) == 0);
      cycle();
      if (i == 400) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
